// File: rtl/hdlc_pkg.sv
// HDLC constants and framer state encoding, shared by the TX framer and the RX path.
package hdlc_pkg;

    localparam logic [7:0] HDLC_FLAG      = 8'h7E;
    localparam logic [7:0] HDLC_ABORT     = 8'hFF;
    localparam int         HDLC_STUFF_RUN = 5;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        OPEN_FLAG  = 3'd1,
        DATA       = 3'd2,
        CLOSE_FLAG = 3'd3,
        ABORT      = 3'd4
    } hdlc_state_e;

endpackage

// File: rtl/hdlc_tx_zero_insert.sv
// Bit stuffer: counts consecutive data 1s and forces a 0 after each run of five.
module hdlc_tx_zero_insert
    import hdlc_pkg::*;
(
    input  logic Clk,
    input  logic Rstn,
    input  logic En,
    input  logic active,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic consume,
    output logic stuff_next
);

    logic [2:0] ones_q, ones_d;
    logic       stuff;

    always_comb begin
        stuff      = (ones_q == 3'(HDLC_STUFF_RUN));
        consume    = active & ~stuff;
        dout       = stuff ? 1'b0 : din;
        // The bit consumed now completes a run, so a stuff bit follows it.
        stuff_next = consume & din & (ones_q == 3'(HDLC_STUFF_RUN - 1));
        ones_d     = ones_q;
        if (En) begin
            if (clr || stuff)
                ones_d = 3'd0;
            else if (active)
                ones_d = din ? ones_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rstn)
            ones_q <= 3'd0;
        else
            ones_q <= ones_d;
    end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: one-byte holding buffer, flag/abort generation and LSB-first
// serialization with zero insertion, advancing one bit per En strobe.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int MIN_FLAGS = 1,
    parameter bit IDLE_FILL = 1'b1
) (
    input  logic       Clk,
    input  logic       Rstn,
    input  logic       En,
    input  logic [7:0] S_Data,
    input  logic       S_Valid,
    input  logic       S_Last,
    output logic       S_Ready,
    output logic       STX,
    output logic       Busy,
    output logic       Underrun
);

    hdlc_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic        cur_last_q, cur_last_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_last_q, buf_last_d;
    logic        buf_full_q, buf_full_d;
    logic [3:0]  flag_cnt_q, flag_cnt_d;
    logic        tail_q, tail_d;
    logic        stx_q, stx_d;
    logic        und_q, und_d;
    logic        rdy_en_q, rdy_en_d;

    logic s_ready, load, decide;
    logic zi_active, zi_dout, zi_consume, zi_stuff_next;

    assign zi_active = (state_q == DATA);

    hdlc_tx_zero_insert u_zi (
        .Clk        (Clk),
        .Rstn       (Rstn),
        .En         (En),
        .active     (zi_active),
        .clr        (~zi_active),
        .din        (sh_q[idx_q]),
        .dout       (zi_dout),
        .consume    (zi_consume),
        .stuff_next (zi_stuff_next)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        cur_last_d = cur_last_q;
        buf_d      = buf_q;
        buf_last_d = buf_last_q;
        buf_full_d = buf_full_q;
        flag_cnt_d = flag_cnt_q;
        tail_d     = tail_q;
        stx_d      = stx_q;
        und_d      = 1'b0;
        rdy_en_d   = 1'b1;
        load       = 1'b0;
        decide     = 1'b0;

        s_ready = rdy_en_q & ~buf_full_q & (state_q != ABORT);
        if (S_Valid && s_ready) begin
            buf_d      = S_Data;
            buf_last_d = S_Last;
            buf_full_d = 1'b1;
        end

        if (En) begin
            case (state_q)
                IDLE: begin
                    stx_d = IDLE_FILL ? HDLC_FLAG[idx_q] : 1'b1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7 && buf_full_q) begin
                        state_d    = OPEN_FLAG;
                        flag_cnt_d = 4'd0;
                    end
                end
                OPEN_FLAG: begin
                    stx_d = HDLC_FLAG[idx_q];
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if (flag_cnt_q == 4'(MIN_FLAGS - 1)) begin
                            state_d = DATA;
                            load    = 1'b1;
                        end else begin
                            flag_cnt_d = flag_cnt_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    stx_d = zi_dout;
                    if (zi_consume) begin
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            if (zi_stuff_next)
                                tail_d = 1'b1;
                            else
                                decide = 1'b1;
                        end
                    end else if (tail_q) begin
                        // Trailing stuff bit of the byte goes out now; decide here.
                        tail_d = 1'b0;
                        decide = 1'b1;
                    end
                    if (decide) begin
                        if (cur_last_q) begin
                            state_d = CLOSE_FLAG;
                        end else if (buf_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ABORT;
                            und_d   = 1'b1;
                        end
                    end
                end
                CLOSE_FLAG: begin
                    stx_d = HDLC_FLAG[idx_q];
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if (buf_full_q) begin
                            state_d    = OPEN_FLAG;
                            flag_cnt_d = 4'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ABORT: begin
                    stx_d = HDLC_ABORT[idx_q];
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7)
                        state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end
            endcase

            if (load) begin
                sh_d       = buf_q;
                cur_last_d = buf_last_q;
                buf_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            sh_q       <= 8'd0;
            cur_last_q <= 1'b0;
            buf_q      <= 8'd0;
            buf_last_q <= 1'b0;
            buf_full_q <= 1'b0;
            flag_cnt_q <= 4'd0;
            tail_q     <= 1'b0;
            stx_q      <= 1'b1;
            und_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            cur_last_q <= cur_last_d;
            buf_q      <= buf_d;
            buf_last_q <= buf_last_d;
            buf_full_q <= buf_full_d;
            flag_cnt_q <= flag_cnt_d;
            tail_q     <= tail_d;
            stx_q      <= stx_d;
            und_q      <= und_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    assign S_Ready  = s_ready;
    assign STX      = stx_q;
    assign Busy     = (state_q != IDLE);
    assign Underrun = und_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Scoreboard bench for hdlc_tx_framer: expected line bits (with Busy/Underrun after
// each bit) are queued by the stimulus and checked on every En edge by a monitor.
module tb_hdlc_tx_framer;

    logic       Clk = 1'b0;
    logic       Rstn = 1'b0;
    logic       En = 1'b1;
    logic [7:0] S_Data = 8'd0;
    logic       S_Valid = 1'b0;
    logic       S_Last = 1'b0;
    logic       S_Ready, STX, Busy, Underrun;

    hdlc_tx_framer #(.MIN_FLAGS(1), .IDLE_FILL(1'b1)) dut (
        .Clk      (Clk),
        .Rstn     (Rstn),
        .En       (En),
        .S_Data   (S_Data),
        .S_Valid  (S_Valid),
        .S_Last   (S_Last),
        .S_Ready  (S_Ready),
        .STX      (STX),
        .Busy     (Busy),
        .Underrun (Underrun)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic stx;
        logic busy;
        logic und;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic last_exp = 1'b1;
    bit   duty = 1'b0;
    int   en_cnt = 0;

    always @(negedge Clk) begin
        en_cnt = en_cnt + 1;
        En = duty ? (en_cnt % 4 == 0) : 1'b1;
    end

    task automatic check(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, req, $time);
        end
    endtask

    // Monitor: compare on each En edge; between En edges STX must hold.
    logic en_s, rst_s;
    exp_t e;
    always @(posedge Clk) begin
        en_s = En;
        rst_s = Rstn;
        #1;
        if (!rst_s) begin
            last_exp = 1'b1;
        end else if (en_s) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                last_exp = e.stx;
                check("stx", STX, e.stx);
                check("busy", Busy, e.busy);
                check("underrun", Underrun, e.und);
            end
        end else begin
            check("stx_hold", STX, last_exp);
        end
    end

    task automatic push_str(input string s, input logic bm, input logic be, input logic ue);
        for (int i = 0; i < s.len(); i++) begin
            exp_t t;
            t.stx  = (s[i] == 8'h31);
            t.busy = (i == s.len() - 1) ? be : bm;
            t.und  = (i == s.len() - 1) ? ue : 1'b0;
            q.push_back(t);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rstn = 1'b0;
        S_Valid = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_stx", STX, 1'b1);
        check("rst_ready", S_Ready, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_underrun", Underrun, 1'b0);
        q.delete();
        Rstn = 1'b1;
        check("ready_at_release", S_Ready, 1'b0);
    endtask

    task automatic chk_ready();
        @(negedge Clk);
        check("ready_after_release", S_Ready, 1'b1);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n;
        S_Data = b;
        S_Last = last;
        S_Valid = 1'b1;
        n = 0;
        while (!S_Ready && n < 400) begin
            @(negedge Clk);
            n++;
        end
        if (!S_Ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=S_Ready low expected=S_Ready high t=%0t", $time);
        end
        @(negedge Clk);
        S_Valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() > 0 && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_%s actual_left=%0d expected_left=0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single byte 0x7E: stuffed to 0111110 10.
        do_reset();
        push_str("01111110", 1'b0, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b1, 1'b0);
        push_str("011111010", 1'b1, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b0, 1'b0);
        push_str("01111110", 1'b0, 1'b0, 1'b0);
        chk_ready();
        send(8'h7E, 1'b1);
        drain("single");

        // {FF, FF(last)}: ones run carries across the byte boundary.
        do_reset();
        push_str("01111110", 1'b0, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b1, 1'b0);
        push_str("1111101111101111101", 1'b1, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b0, 1'b0);
        push_str("01111110", 1'b0, 1'b0, 1'b0);
        chk_ready();
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        drain("ffff");

        // {1F(last)}: stuff bit right after bit 4.
        do_reset();
        push_str("01111110", 1'b0, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b1, 1'b0);
        push_str("111110000", 1'b1, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b0, 1'b0);
        push_str("01111110", 1'b0, 1'b0, 1'b0);
        chk_ready();
        send(8'h1F, 1'b1);
        drain("1f");

        // Underrun: 0x00 not last, then nothing -> abort.
        do_reset();
        push_str("01111110", 1'b0, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b1, 1'b0);
        push_str("00000000", 1'b1, 1'b1, 1'b1);
        push_str("11111111", 1'b1, 1'b0, 1'b0);
        push_str("01111110", 1'b0, 1'b0, 1'b0);
        chk_ready();
        send(8'h00, 1'b0);
        drain("underrun");

        // Back-to-back frames {55(last)} then {AA(last)}.
        do_reset();
        push_str("01111110", 1'b0, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b1, 1'b0);
        push_str("10101010", 1'b1, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b1, 1'b0);
        push_str("01010101", 1'b1, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b0, 1'b0);
        push_str("01111110", 1'b0, 1'b0, 1'b0);
        chk_ready();
        send(8'h55, 1'b1);
        send(8'hAA, 1'b1);
        drain("b2b");

        // En at 1/4 duty, reset three data bits into {0F(last)}.
        duty = 1'b1;
        do_reset();
        push_str("01111110", 1'b0, 1'b1, 1'b0);
        push_str("01111110", 1'b1, 1'b1, 1'b0);
        push_str("111", 1'b1, 1'b1, 1'b0);
        chk_ready();
        send(8'h0F, 1'b1);
        drain("duty");
        do_reset();
        push_str("01111110", 1'b0, 1'b0, 1'b0);
        chk_ready();
        drain("duty_idle");
        duty = 1'b0;

        repeat (4) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_framer.md
# hdlc_tx_framer

HDLC transmit framer: accepts frame bytes over a valid/ready byte stream and serializes them LSB-first onto a single bit line. It emits opening and closing flags (0x7E), inserts a 0 after every five consecutive 1s of frame content, and sends an abort sequence on source underrun. It is the transmit-side counterpart of the serial receive path's zero-delete stage and runs on the same per-bit enable strobe.

## Interface
- MIN_FLAGS, 1: number of opening flags sent before the first data byte (1..15).
- IDLE_FILL, 1: idle line content; 1 = continuous flags, 0 = continuous 1s (mark).
- Clk  in  1  clock.
- Rstn  in  1  reset, synchronous, active-low.
- En  in  1  bit-rate strobe; one output bit per Clk with En=1.
- S_Data  in  8  frame byte.
- S_Valid  in  1  S_Data/S_Last valid.
- S_Last  in  1  byte is the last of the frame.
- S_Ready  out  1  one-byte holding buffer empty.
- STX  out  1  serial tx data, registered.
- Busy  out  1  state != IDLE.
- Underrun  out  1  one-Clk pulse when a frame is aborted.

## Operation
- Holding buffer: one byte plus its last flag. S_Ready = buffer empty and state != ABORT. A transfer occurs on any Clk with S_Valid & S_Ready, independent of En.
- Shifter: 8-bit register plus bit index 0..7. One bit is consumed per En cycle, LSB first. On the cycle that consumes bit 7, the next byte is loaded from the buffer if one is present.
- States and transitions:
  - IDLE: emits 0x7E (IDLE_FILL=1) or 1s (IDLE_FILL=0) in 8-bit groups. At a group boundary with the buffer full, go to OPEN_FLAG.
  - OPEN_FLAG: emits MIN_FLAGS x 0x7E, then DATA with the first byte loaded.
  - DATA: emits byte bits with zero insertion. At each byte end:
    - current byte had last=1: go to CLOSE_FLAG.
    - buffer full: load the next byte, stay in DATA.
    - buffer empty: go to ABORT and pulse Underrun.
  - CLOSE_FLAG: emits 0x7E. Then go to OPEN_FLAG if the buffer is full, else IDLE.
  - ABORT: emits 8 ones (0xFF), then IDLE.
- Zero insertion:
  - A ones counter (0..5) counts DATA bits only.
  - When the counter reaches 5, the next En cycle emits 0 without consuming a data bit, and the counter clears.
  - An emitted 0 data bit also clears the counter.
  - The counter carries across byte boundaries.
  - The counter clears on entry to every flag and abort state.
  - A stuff bit pending after the last bit of a byte is emitted before the byte-end decision.
- Flags and abort bits are never stuffed.

## Timing
- Reset values:
  - STX=1, S_Ready=0, Busy=0, Underrun=0.
  - state=IDLE, buffer empty, counter 0, bit index 0.
  - S_Ready rises on the first Clk after reset release.
- STX changes only on Clk edges where En=1 and holds otherwise. All state, counter and index updates occur only on En cycles, except buffer fill and Underrun.
- Byte-end decision is made on the En cycle that consumes bit 7, or on the cycle that emits the trailing stuff bit if one is pending. Buffer contents are sampled at that edge.
- Simultaneous load: a byte written on the same Clk as the decision is not seen at that decision.
- Latency: a byte accepted in IDLE appears on STX after the remainder of the current idle group, plus 8*MIN_FLAGS bits.
- Back-to-back frames: the closing flag is followed directly by MIN_FLAGS opening flags; no idle group in between.
- En held low: everything except buffer fill freezes.
- Reset mid-frame: immediate return to reset values. The partial frame is dropped with no abort.

## Structure
- Package hdlc_pkg:
  - HDLC_FLAG=8'h7E, HDLC_ABORT=8'hFF, HDLC_STUFF_RUN=5.
  - State enum {IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT}.
  - Shared with the RX path.
- Sub-module hdlc_tx_zero_insert: bit-level stuffer containing the ones counter, a consume-strobe output and a clear input. The framer FSM and buffer stay in hdlc_tx_framer.

## Test plan
- Single byte 0x7E, last=1, MIN_FLAGS=1, IDLE_FILL=1 -> after idle flags, STX = 01111110, 0111110 10, 01111110, then idle flags. Busy high from OPEN_FLAG through CLOSE_FLAG.
- Frame {0xFF, 0xFF(last)} -> data bits 11111 0 11111 0 11111 0 1 (19 bits), then closing flag 01111110. The counter carries across the byte boundary.
- Frame {0x1F(last)} -> 11111 0 000 (stuff bit after bit 4), then the closing flag.
- Underrun: 2-byte frame, first byte 0x00 last=0, S_Valid held low afterwards -> 00000000, then 11111111, Underrun one-Clk pulse at the decision edge, then IDLE.
- Back-to-back: frame A {0x55(last)} with frame B {0xAA(last)} already buffered -> A data, 01111110, one opening flag, B data. No idle group between frames.
- En duty 1/4 with reset asserted mid-DATA -> STX updates only on En edges. After Rstn low: STX=1, S_Ready=0, Busy=0; then S_Ready=1 one Clk after release.
